uart_frame_decoder: RTL and testbench
=====================================

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 16_000_000: system clock frequency, used only for the timeout constant.
REQ-002 Parameter MAX_LEN, default 16: maximum payload bytes per frame.
REQ-003 Parameter TIMEOUT_CLKS, default 16_000: maximum idle clocks between bytes inside a frame (1 ms at 16 MHz).
REQ-004 Parameter SYNC_BYTE, default 8'hAA: frame start marker.
REQ-005 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-006 i_Clock  in  1  sole clock; all logic on its rising edge.
REQ-007 i_Rst_n  in  1  asynchronous active-low reset.
REQ-008 i_Rx_DV  in  1  one-cycle strobe from the upstream UART receiver; byte valid.
REQ-009 i_Rx_Byte  in  8  received byte; sampled only when i_Rx_DV=1.
REQ-010 i_Frame_Ack  in  1  consumer accepts the pending frame.
REQ-011 i_Rd_Addr  in  $clog2(MAX_LEN)  payload buffer read index.
REQ-012 o_Rd_Data  out  8  payload byte at i_Rd_Addr; combinational read.
REQ-013 o_Frame_Valid  out  1  level; a complete, checked frame is held.
REQ-014 o_Cmd  out  8  command byte of the held frame.
REQ-015 o_Len  out  $clog2(MAX_LEN)+1  payload length of the held frame.
REQ-016 o_Err_Csum, o_Err_Len, o_Err_Timeout, o_Overrun  out  1 each  one-cycle error pulses.

Function
REQ-017 Frame format: SYNC_BYTE, CMD, LEN, LEN payload bytes, CSUM; CSUM = XOR of CMD, LEN and all payload bytes.
REQ-018 States: IDLE, CMD, LEN, PAYLOAD, CSUM, HOLD.
REQ-019 IDLE: byte == SYNC_BYTE -> CMD; any other byte is discarded silently.
REQ-020 CMD: store the byte, seed the running XOR with it -> LEN.
REQ-021 LEN: if the value is greater than MAX_LEN, pulse o_Err_Len and go to IDLE; if 0 -> CSUM; otherwise -> PAYLOAD with the write index cleared.
REQ-022 PAYLOAD: write the byte to buffer[index], XOR it into the running sum, increment the index; after the LEN-th byte -> CSUM.
REQ-023 CSUM: if the byte matches the running XOR -> HOLD, otherwise pulse o_Err_Csum and go to IDLE.
REQ-024 o_Frame_Valid rises on the clock edge after the CSUM strobe and stays high throughout HOLD.
REQ-025 During HOLD, o_Cmd, o_Len and the buffer contents are stable.
REQ-026 HOLD: i_Frame_Ack=1 -> IDLE on the next edge, and o_Frame_Valid falls on that edge.
REQ-027 i_Frame_Ack is ignored outside HOLD.
REQ-028 Any i_Rx_DV during HOLD drops the byte and pulses o_Overrun, including when i_Frame_Ack is high in the same cycle; the frame is still released.
REQ-029 Timeout counter: clears on every i_Rx_DV and on entry to CMD.
REQ-030 Timeout counter: counts only in CMD, LEN, PAYLOAD and CSUM; saturates at TIMEOUT_CLKS.
REQ-031 When the counter reaches TIMEOUT_CLKS, pulse o_Err_Timeout and go to IDLE; IDLE and HOLD never time out.
REQ-032 A SYNC_BYTE value received mid-frame is treated as data; there is no resynchronisation.
REQ-033 Error pulses are registered, last exactly one cycle, and are mutually exclusive.
REQ-034 Inputs are assumed already synchronous to i_Clock; no input synchronisers.

Reset
REQ-035 Asserting i_Rst_n low, at any time including mid-frame or in HOLD, forces IDLE asynchronously.
REQ-036 Reset clears o_Frame_Valid, all error pulses, o_Cmd=0, o_Len=0, the XOR accumulator, the index and the timeout counter.
REQ-037 Buffer contents are not reset; o_Rd_Data is undefined until the first frame.
REQ-038 Deassertion is used synchronously; the first byte is accepted on the first edge after release.

Structure
REQ-039 Shared package/include uart_frame_pkg holds the state encoding, the SYNC_BYTE default and the MAX_LEN default.
REQ-040 One sub-module, uart_frame_timeout, holds the saturating inter-byte counter (inputs clear and enable; output expired).
REQ-041 The payload buffer is an inferred register array.

Verification
REQ-042 Bytes AA 01 02 10 20 33 -> o_Frame_Valid=1 one cycle after the last strobe; o_Cmd=01, o_Len=2, buffer[0]=10, buffer[1]=20; held until the ack, low the cycle after the ack.
REQ-043 Bytes AA 05 00 05 -> valid frame with o_Len=0; bytes 55 AA 05 00 05 -> the leading 55 is ignored and the same frame is produced.
REQ-044 Bytes AA 01 02 10 20 34 -> one o_Err_Csum pulse, o_Frame_Valid stays 0; the next good frame is accepted.
REQ-045 Bytes AA 01 11 (LEN=17 with MAX_LEN=16) -> o_Err_Len pulse, return to IDLE.
REQ-046 Bytes AA 01 02 10, then silence -> o_Err_Timeout exactly TIMEOUT_CLKS cycles after the 10 strobe; the next frame decodes normally.
REQ-047 Held frame, then a byte strobe coincident with i_Frame_Ack -> o_Overrun pulse and the frame released; reset asserted mid-PAYLOAD -> o_Frame_Valid=0, IDLE, no error pulse.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame decoder: FSM encoding and parameter defaults.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;
  localparam int         DEFAULT_MAX_LEN   = 16;

  // States in which the inter-byte timeout is armed.
  function automatic logic in_frame(input state_t s);
    return (s == ST_CMD) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-stream input, held-frame output and payload read port of the frame decoder.
interface uart_frame_decoder_if #(
  parameter int MAX_LEN = 16
);
  import uart_frame_pkg::*;

  // i_Rx_DV is a one-cycle strobe with no backpressure; a frame is offered while
  // o_Frame_Valid is high and transfers on the edge where i_Frame_Ack is sampled high.
  logic                         i_Rx_DV;
  logic [7:0]                   i_Rx_Byte;
  logic                         i_Frame_Ack;
  logic [$clog2(MAX_LEN)-1:0]   i_Rd_Addr;
  logic [7:0]                   o_Rd_Data;
  logic                         o_Frame_Valid;
  logic [7:0]                   o_Cmd;
  logic [$clog2(MAX_LEN):0]     o_Len;
  logic                         o_Err_Csum;
  logic                         o_Err_Len;
  logic                         o_Err_Timeout;
  logic                         o_Overrun;
  state_t                       dbg_state;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Frame_Ack, i_Rd_Addr,
    input  o_Rd_Data, o_Frame_Valid, o_Cmd, o_Len,
    input  o_Err_Csum, o_Err_Len, o_Err_Timeout, o_Overrun, dbg_state
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Frame_Ack, i_Rd_Addr,
    output o_Rd_Data, o_Frame_Valid, o_Cmd, o_Len,
    output o_Err_Csum, o_Err_Len, o_Err_Timeout, o_Overrun, dbg_state
  );

endinterface

// File: rtl/uart_frame_timeout.sv
// Saturating inter-byte idle counter; expired flags the edge that brings it to TIMEOUT_CLKS.
module uart_frame_timeout #(
  parameter int TIMEOUT_CLKS = 16_000
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT_CLKS))) begin
      count <= count + CW'(1);
    end
  end

  // Asserted in the cycle whose closing edge lands the count on TIMEOUT_CLKS.
  assign expired = enable && !clear && (count >= CW'(TIMEOUT_CLKS - 1));

endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes SYNC/CMD/LEN/payload/CSUM frames from a UART byte stream and holds each good frame until acked.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         CLK_FREQ_HZ  = 16_000_000,
  parameter int         MAX_LEN      = DEFAULT_MAX_LEN,
  parameter int         TIMEOUT_CLKS = CLK_FREQ_HZ / 1000,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  uart_frame_decoder_if.slave bus
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN) + 1;

  state_t        state, next_state;
  logic [7:0]    cmd_q;
  logic [LW-1:0] len_q;
  logic [7:0]    xor_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    mem [MAX_LEN];
  logic          err_csum_d, err_len_d, err_tmo_d, overrun_d;
  logic          err_csum_q, err_len_q, err_tmo_q, overrun_q;
  logic          expired;
  logic          rx;
  logic          last_payload;

  assign rx           = bus.i_Rx_DV;
  assign last_payload = ((LW'(idx_q) + LW'(1)) == len_q);

  uart_frame_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .clear   (rx),
    .enable  (in_frame(state)),
    .expired (expired)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    err_csum_d = 1'b0;
    err_len_d  = 1'b0;
    err_tmo_d  = 1'b0;
    overrun_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx && (bus.i_Rx_Byte == SYNC_BYTE)) next_state = ST_CMD;
      end
      ST_CMD: begin
        if (rx) next_state = ST_LEN;
        else if (expired) begin next_state = ST_IDLE; err_tmo_d = 1'b1; end
      end
      ST_LEN: begin
        if (rx) begin
          if (bus.i_Rx_Byte > 8'(MAX_LEN)) begin
            next_state = ST_IDLE;
            err_len_d  = 1'b1;
          end else if (bus.i_Rx_Byte == 8'd0) begin
            next_state = ST_CSUM;
          end else begin
            next_state = ST_PAYLOAD;
          end
        end else if (expired) begin next_state = ST_IDLE; err_tmo_d = 1'b1; end
      end
      ST_PAYLOAD: begin
        if (rx) begin
          if (last_payload) next_state = ST_CSUM;
        end else if (expired) begin next_state = ST_IDLE; err_tmo_d = 1'b1; end
      end
      ST_CSUM: begin
        if (rx) begin
          if (bus.i_Rx_Byte == xor_q) next_state = ST_HOLD;
          else begin next_state = ST_IDLE; err_csum_d = 1'b1; end
        end else if (expired) begin next_state = ST_IDLE; err_tmo_d = 1'b1; end
      end
      ST_HOLD: begin
        // A byte arriving while a frame is held is dropped, even on the ack cycle.
        if (rx) overrun_d = 1'b1;
        if (bus.i_Frame_Ack) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cmd_q      <= '0;
      len_q      <= '0;
      xor_q      <= '0;
      idx_q      <= '0;
      err_csum_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      err_csum_q <= err_csum_d;
      err_len_q  <= err_len_d;
      err_tmo_q  <= err_tmo_d;
      overrun_q  <= overrun_d;
      if (rx) begin
        case (state)
          ST_CMD: begin
            cmd_q <= bus.i_Rx_Byte;
            xor_q <= bus.i_Rx_Byte;
          end
          ST_LEN: begin
            if (bus.i_Rx_Byte <= 8'(MAX_LEN)) len_q <= bus.i_Rx_Byte[LW-1:0];
            xor_q <= xor_q ^ bus.i_Rx_Byte;
            idx_q <= '0;
          end
          ST_PAYLOAD: begin
            xor_q <= xor_q ^ bus.i_Rx_Byte;
            idx_q <= idx_q + AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Payload storage carries no reset so it maps onto plain register arrays.
  always_ff @(posedge i_Clock) begin
    if (rx && (state == ST_PAYLOAD)) mem[idx_q] <= bus.i_Rx_Byte;
  end

  assign bus.o_Rd_Data     = mem[bus.i_Rd_Addr];
  assign bus.o_Frame_Valid = (state == ST_HOLD);
  assign bus.o_Cmd         = cmd_q;
  assign bus.o_Len         = len_q;
  assign bus.o_Err_Csum    = err_csum_q;
  assign bus.o_Err_Len     = err_len_q;
  assign bus.o_Err_Timeout = err_tmo_q;
  assign bus.o_Overrun     = overrun_q;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed self-checking bench for uart_frame_decoder with hand-computed frames.
module tb_uart_frame_decoder;
  import uart_frame_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 64;

  typedef logic [7:0] byte_q_t[$];

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [7:0] exp_q[$];

  uart_frame_decoder_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_frame_decoder #(
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TMO),
    .SYNC_BYTE    (8'hAA)
  ) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    @(negedge clk);
    bus.i_Rx_DV   = 1'b0;
  endtask

  task automatic send_burst(input byte_q_t bytes);
    foreach (bytes[i]) begin
      @(negedge clk);
      bus.i_Rx_DV   = 1'b1;
      bus.i_Rx_Byte = bytes[i];
    end
    @(negedge clk);
    bus.i_Rx_DV = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.i_Frame_Ack = 1'b1;
    @(negedge clk);
    bus.i_Frame_Ack = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_Frame_Valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", bus.o_Frame_Valid); errors++; end
    checks++;
    if (bus.o_Cmd !== 8'h00 || bus.o_Len !== 5'd0) begin $display("FAIL reset_cmd_len: got cmd=%h len=%0d want 00/0", bus.o_Cmd, bus.o_Len); errors++; end
    checks++;
    if ({bus.o_Err_Csum, bus.o_Err_Len, bus.o_Err_Timeout, bus.o_Overrun} !== 4'b0000) begin
      $display("FAIL reset_errs: got %b want 0000", {bus.o_Err_Csum, bus.o_Err_Len, bus.o_Err_Timeout, bus.o_Overrun}); errors++;
    end
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, ST_IDLE); errors++; end
    // Release and strobe the sync byte straight away: it must be taken on the first edge.
    rst_n = 1'b1;
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = 8'hAA;
    @(negedge clk);
    bus.i_Rx_DV = 1'b0;
    checks++;
    if (bus.dbg_state !== ST_CMD) begin $display("FAIL first_byte_after_reset: got state %0d want %0d", bus.dbg_state, ST_CMD); errors++; end
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
    checks++;
    if (bus.o_Frame_Valid !== 1'b1) begin $display("FAIL first_frame_valid: got %b want 1", bus.o_Frame_Valid); errors++; end
    pulse_ack();
  endtask

  task automatic test_basic_frame();
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
    checks++;
    if (bus.o_Frame_Valid !== 1'b0) begin $display("FAIL basic_valid_early: got %b want 0", bus.o_Frame_Valid); errors++; end
    send_byte(8'h33);
    checks++;
    if (bus.o_Frame_Valid !== 1'b1) begin $display("FAIL basic_valid: got %b want 1", bus.o_Frame_Valid); errors++; end
    checks++;
    if (bus.o_Cmd !== 8'h01 || bus.o_Len !== 5'd2) begin $display("FAIL basic_cmd_len: got %h/%0d want 01/2", bus.o_Cmd, bus.o_Len); errors++; end
    bus.i_Rd_Addr = 4'd0; #1;
    checks++;
    if (bus.o_Rd_Data !== 8'h10) begin $display("FAIL basic_buf0: got %h want 10", bus.o_Rd_Data); errors++; end
    bus.i_Rd_Addr = 4'd1; #1;
    checks++;
    if (bus.o_Rd_Data !== 8'h20) begin $display("FAIL basic_buf1: got %h want 20", bus.o_Rd_Data); errors++; end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.o_Frame_Valid !== 1'b1 || bus.o_Cmd !== 8'h01) begin $display("FAIL basic_hold: got valid=%b cmd=%h want 1/01", bus.o_Frame_Valid, bus.o_Cmd); errors++; end
    pulse_ack();
    checks++;
    if (bus.o_Frame_Valid !== 1'b0) begin $display("FAIL basic_release: got %b want 0", bus.o_Frame_Valid); errors++; end
  endtask

  task automatic test_zero_len();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
    checks++;
    if (bus.o_Frame_Valid !== 1'b1 || bus.o_Len !== 5'd0 || bus.o_Cmd !== 8'h05) begin
      $display("FAIL zero_len: got valid=%b len=%0d cmd=%h want 1/0/05", bus.o_Frame_Valid, bus.o_Len, bus.o_Cmd); errors++;
    end
    pulse_ack();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
    checks++;
    if (bus.o_Frame_Valid !== 1'b1 || bus.o_Len !== 5'd0 || bus.o_Cmd !== 8'h05) begin
      $display("FAIL leading_junk: got valid=%b len=%0d cmd=%h want 1/0/05", bus.o_Frame_Valid, bus.o_Len, bus.o_Cmd); errors++;
    end
    pulse_ack();
  endtask

  task automatic test_csum_err();
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h34);
    checks++;
    if (bus.o_Err_Csum !== 1'b1 || bus.o_Frame_Valid !== 1'b0) begin
      $display("FAIL csum_pulse: got err=%b valid=%b want 1/0", bus.o_Err_Csum, bus.o_Frame_Valid); errors++;
    end
    @(negedge clk);
    checks++;
    if (bus.o_Err_Csum !== 1'b0) begin $display("FAIL csum_one_cycle: got %b want 0", bus.o_Err_Csum); errors++; end
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7C);
    bus.i_Rd_Addr = 4'd0; #1;
    checks++;
    if (bus.o_Frame_Valid !== 1'b1 || bus.o_Rd_Data !== 8'h7E) begin
      $display("FAIL csum_recover: got valid=%b buf0=%h want 1/7e", bus.o_Frame_Valid, bus.o_Rd_Data); errors++;
    end
    pulse_ack();
  endtask

  task automatic test_len_err();
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h11);
    checks++;
    if (bus.o_Err_Len !== 1'b1 || bus.dbg_state !== ST_IDLE) begin
      $display("FAIL len_err: got err=%b state=%0d want 1/%0d", bus.o_Err_Len, bus.dbg_state, ST_IDLE); errors++;
    end
    @(negedge clk);
    checks++;
    if (bus.o_Err_Len !== 1'b0) begin $display("FAIL len_err_one_cycle: got %b want 0", bus.o_Err_Len); errors++; end
  endtask

  task automatic test_max_len();
    byte_q_t frame;
    logic [7:0] x;
    logic [7:0] got;
    frame = '{8'hAA, 8'h42, 8'h10};
    x = 8'h42 ^ 8'h10;
    for (int k = 0; k < MAX_LEN; k++) begin
      frame.push_back(8'(k * 3 + 1));
      exp_q.push_back(8'(k * 3 + 1));
      x = x ^ 8'(k * 3 + 1);
    end
    frame.push_back(x);
    send_burst(frame);
    checks++;
    if (bus.o_Frame_Valid !== 1'b1 || bus.o_Len !== 5'd16) begin
      $display("FAIL max_len: got valid=%b len=%0d want 1/16", bus.o_Frame_Valid, bus.o_Len); errors++;
    end
    for (int k = 0; k < MAX_LEN; k++) begin
      bus.i_Rd_Addr = 4'(k); #1;
      got = exp_q.pop_front();
      checks++;
      if (bus.o_Rd_Data !== got) begin $display("FAIL max_len_buf%0d: got %h want %h", k, bus.o_Rd_Data, got); errors++; end
    end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    byte_q_t frame;
    frame = '{8'hAA, 8'h02, 8'h01, 8'h5A, 8'h59};
    send_burst(frame);
    bus.i_Rd_Addr = 4'd0; #1;
    checks++;
    if (bus.o_Frame_Valid !== 1'b1 || bus.o_Cmd !== 8'h02 || bus.o_Rd_Data !== 8'h5A) begin
      $display("FAIL back_to_back: got valid=%b cmd=%h buf0=%h want 1/02/5a", bus.o_Frame_Valid, bus.o_Cmd, bus.o_Rd_Data); errors++;
    end
    pulse_ack();
  endtask

  task automatic test_timeout();
    int early;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h10);
    early = 0;
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk);
      if (bus.o_Err_Timeout !== 1'b0) early++;
    end
    checks++;
    if (early != 0 || bus.dbg_state !== ST_PAYLOAD) begin
      $display("FAIL timeout_early: got early=%0d state=%0d want 0/%0d", early, bus.dbg_state, ST_PAYLOAD); errors++;
    end
    @(negedge clk);
    checks++;
    if (bus.o_Err_Timeout !== 1'b1 || bus.dbg_state !== ST_IDLE) begin
      $display("FAIL timeout_pulse: got err=%b state=%0d want 1/%0d", bus.o_Err_Timeout, bus.dbg_state, ST_IDLE); errors++;
    end
    @(negedge clk);
    checks++;
    if (bus.o_Err_Timeout !== 1'b0) begin $display("FAIL timeout_one_cycle: got %b want 0", bus.o_Err_Timeout); errors++; end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h33);
    checks++;
    if (bus.o_Frame_Valid !== 1'b1 || bus.o_Cmd !== 8'h01) begin
      $display("FAIL timeout_recover: got valid=%b cmd=%h want 1/01", bus.o_Frame_Valid, bus.o_Cmd); errors++;
    end
    pulse_ack();
  endtask

  task automatic test_ack_outside_hold();
    pulse_ack();
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h10);
    pulse_ack();
    send_byte(8'h20); send_byte(8'h33);
    checks++;
    if (bus.o_Frame_Valid !== 1'b1) begin $display("FAIL ack_ignored: got %b want 1", bus.o_Frame_Valid); errors++; end
    pulse_ack();
  endtask

  task automatic test_overrun();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h77);
    checks++;
    if (bus.o_Overrun !== 1'b1 || bus.o_Frame_Valid !== 1'b1) begin
      $display("FAIL overrun_hold: got ovr=%b valid=%b want 1/1", bus.o_Overrun, bus.o_Frame_Valid); errors++;
    end
    @(negedge clk);
    bus.i_Rx_DV = 1'b1; bus.i_Rx_Byte = 8'hAA; bus.i_Frame_Ack = 1'b1;
    @(negedge clk);
    bus.i_Rx_DV = 1'b0; bus.i_Frame_Ack = 1'b0;
    checks++;
    if (bus.o_Overrun !== 1'b1 || bus.o_Frame_Valid !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
      $display("FAIL overrun_ack: got ovr=%b valid=%b state=%0d want 1/0/%0d", bus.o_Overrun, bus.o_Frame_Valid, bus.dbg_state, ST_IDLE); errors++;
    end
    // The dropped AA must not have started a frame.
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
    checks++;
    if (bus.o_Frame_Valid !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
      $display("FAIL overrun_dropped: got valid=%b state=%0d want 0/%0d", bus.o_Frame_Valid, bus.dbg_state, ST_IDLE); errors++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03); send_byte(8'h10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dbg_state !== ST_IDLE || bus.o_Frame_Valid !== 1'b0 || bus.o_Cmd !== 8'h00) begin
      $display("FAIL async_reset: got state=%0d valid=%b cmd=%h want %0d/0/00", bus.dbg_state, bus.o_Frame_Valid, bus.o_Cmd, ST_IDLE); errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if ({bus.o_Err_Csum, bus.o_Err_Len, bus.o_Err_Timeout, bus.o_Overrun} !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin $display("FAIL reset_no_err: got %0d pulse cycles want 0", bad); errors++; end
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
    checks++;
    if (bus.o_Frame_Valid !== 1'b1) begin $display("FAIL reset_recover: got %b want 1", bus.o_Frame_Valid); errors++; end
    pulse_ack();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.i_Rx_DV     = 1'b0;
    bus.i_Rx_Byte   = 8'h00;
    bus.i_Frame_Ack = 1'b0;
    bus.i_Rd_Addr   = '0;
    test_reset();
    test_basic_frame();
    test_zero_len();
    test_csum_err();
    test_len_err();
    test_max_len();
    test_back_to_back();
    test_timeout();
    test_ack_outside_hold();
    test_overrun();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
